// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I front end.
package rv32i_pkg;

    typedef enum logic [0:0] {
        FS_RUN   = 1'b0,
        FS_DRAIN = 1'b1
    } fetch_state_t;

    // addi x0, x0, 0 -- harmless filler written into the ring on a redirect
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_ring.sv
// Fetch buffer storage: the address is written at issue, the data on
// response, and the head entry is read combinationally for decode.
module fetch_ring #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_addr_we,
    input  logic [$clog2(DEPTH)-1:0] i_wp,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic                     i_data_we,
    input  logic [$clog2(DEPTH)-1:0] i_fp,
    input  logic [DATA_W-1:0]        i_data,
    input  logic [$clog2(DEPTH)-1:0] i_rp,
    output logic [ADDR_W-1:0]        o_addr,
    output logic [DATA_W-1:0]        o_data
);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    // Independent address and data write ports; storage clears on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (i_addr_we) begin
                r_addr[i_wp] <= i_addr;
            end
            if (i_data_we) begin
                r_data[i_fp] <= i_data;
            end
        end
    end

    assign o_addr = r_addr[i_rp];
    assign o_data = r_data[i_rp];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order instruction memory requests from the PC,
// buffers responses in a ring and hands {instr, addr} to decode. A flush
// discards everything; responses still owed for the wrong path are then
// swallowed in DRAIN before fetching resumes.
module instr_fetch_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              pc_valid,
    output logic              pc_stall,
    input  logic              flush,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_addr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_state_t     r_state;
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_fp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_n_infl;
    logic [CNT_W-1:0] r_n_buf;
    logic [CNT_W-1:0] r_n_drop;

    logic             w_run;
    logic [CNT_W-1:0] w_occ;
    logic             w_room;
    logic             w_issue;
    logic             w_rsp_run;
    logic             w_rsp_drain;
    logic             w_consume;
    logic [CNT_W-1:0] w_stale;
    logic [CNT_W-1:0] w_drop_nxt;
    logic             w_data_we;
    logic [PTR_W-1:0] w_data_idx;
    logic [DATA_W-1:0] w_data_wr;

    assign w_run   = (r_state == FS_RUN);
    assign w_occ   = r_n_infl + r_n_buf;
    assign w_room  = (w_occ < CNT_W'(DEPTH));

    // Reset gating keeps the handshake outputs quiet while rst is held low
    assign imem_req_valid = rst & pc_valid & ~flush & w_run & w_room;
    assign imem_req_addr  = pc_addr;
    assign w_issue        = imem_req_valid & imem_req_ready;
    assign pc_stall       = rst & pc_valid & ~w_issue;

    // A response with nothing in flight is ignored rather than corrupting the ring
    assign w_rsp_run   = imem_rsp_valid & w_run & (r_n_infl != '0);
    assign w_rsp_drain = imem_rsp_valid & ~w_run & (r_n_drop != '0);

    assign id_valid  = (r_n_buf != '0);
    assign w_consume = id_valid & id_ready;

    // Responses still owed after a flush; one arriving in the flush cycle is already paid
    assign w_stale    = r_n_infl - CNT_W'(w_rsp_run);
    assign w_drop_nxt = r_n_drop - CNT_W'(w_rsp_drain);

    // A redirect parks a NOP in slot 0 so a stray read of the empty ring decodes harmlessly
    assign w_data_we  = w_rsp_run | flush;
    assign w_data_idx = flush ? '0 : r_fp;
    assign w_data_wr  = flush ? DATA_W'(NOP_INSTR) : imem_rsp_data;

    fetch_ring #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .i_addr_we (w_issue),
        .i_wp      (r_wp),
        .i_addr    (pc_addr),
        .i_data_we (w_data_we),
        .i_fp      (w_data_idx),
        .i_data    (w_data_wr),
        .i_rp      (r_rp),
        .o_addr    (id_addr),
        .o_data    (id_instr)
    );

    // Pointers, occupancy counters and the RUN/DRAIN state machine
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= FS_RUN;
            r_wp     <= '0;
            r_fp     <= '0;
            r_rp     <= '0;
            r_n_infl <= '0;
            r_n_buf  <= '0;
            r_n_drop <= '0;
        end else begin
            if (flush) begin
                r_wp     <= '0;
                r_fp     <= '0;
                r_rp     <= '0;
                r_n_infl <= '0;
                r_n_buf  <= '0;
            end else begin
                if (w_issue) begin
                    r_wp <= r_wp + PTR_W'(1);
                end
                if (w_rsp_run) begin
                    r_fp <= r_fp + PTR_W'(1);
                end
                if (w_consume) begin
                    r_rp <= r_rp + PTR_W'(1);
                end
                r_n_infl <= r_n_infl + CNT_W'(w_issue) - CNT_W'(w_rsp_run);
                r_n_buf  <= r_n_buf + CNT_W'(w_rsp_run) - CNT_W'(w_consume);
            end

            case (r_state)
                FS_RUN: begin
                    if (flush) begin
                        r_n_drop <= w_stale;
                        r_state  <= (w_stale != '0) ? FS_DRAIN : FS_RUN;
                    end
                end
                FS_DRAIN: begin
                    r_n_drop <= w_drop_nxt;
                    r_state  <= (w_drop_nxt == '0) ? FS_RUN : FS_DRAIN;
                end
                default: begin
                    r_state <= FS_RUN;
                end
            endcase
        end
    end

    // Memory must never answer a request that was not issued
    always @(posedge clk) begin
        if (rst) begin
            assert (!(imem_rsp_valid && w_run && (r_n_infl == '0)))
                else $error("instr_fetch_unit: imem response with no request in flight");
        end
    end

endmodule
